// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit for the execute stage.
//            A radix-2 shift-add multiplier and a restoring divider share
//            one 2*DATA_WIDTH accumulator and take one bit per cycle.
// Ports    : clk       - rising-edge clock
//            reset     - asynchronous active-low reset
//            start     - request, sampled only in IDLE
//            flush     - abort any operation, back to IDLE next edge
//            Operation - 000 MUL .. 111 REMU (RV32M funct3 order)
//            SrcA/SrcB - rs1 / rs2 operands
//            busy      - high in CALC and FINISH
//            done      - one-cycle pulse, Result valid in that cycle
//            Result    - result, held until the next accepted start
// Options  : `define MULDIV_ZERO_SKIP_EN to finish multiplies with a zero
//            operand in one cycle instead of DATA_WIDTH+1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int          c_CW     = $clog2(DATA_WIDTH);
  localparam logic [1:0]  c_IDLE   = 2'd0;
  localparam logic [1:0]  c_CALC   = 2'd1;
  localparam logic [1:0]  c_FINISH = 2'd2;

  localparam logic [2:0]  c_MUL    = 3'b000;
  localparam logic [2:0]  c_MULH   = 3'b001;
  localparam logic [2:0]  c_MULHSU = 3'b010;
  localparam logic [2:0]  c_DIV    = 3'b100;
  localparam logic [2:0]  c_REM    = 3'b110;

  localparam logic [DATA_WIDTH-1:0] c_MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]              r_state, w_next;
  logic [2:0]              r_op;
  logic [DATA_WIDTH-1:0]   r_a, r_b, r_result;
  logic [2*DATA_WIDTH-1:0] r_acc;
  logic [c_CW-1:0]         r_cnt;
  logic                    r_neg, r_neg_rem, r_special;

  // ---------------- operand decode / special cases ----------------
  logic                  w_a_signed, w_b_signed, w_sign_a, w_sign_b;
  logic [DATA_WIDTH-1:0] w_mag_a, w_mag_b;
  logic                  w_div0, w_ovf, w_mul_zero, w_special, w_accept;
  logic [DATA_WIDTH-1:0] w_spec_val;

  assign w_a_signed = (Operation == c_DIV) || (Operation == c_REM) ||
                      (Operation == c_MULH) || (Operation == c_MULHSU);
  assign w_b_signed = (Operation == c_DIV) || (Operation == c_REM) ||
                      (Operation == c_MULH);
  assign w_sign_a   = w_a_signed & SrcA[DATA_WIDTH-1];
  assign w_sign_b   = w_b_signed & SrcB[DATA_WIDTH-1];
  assign w_mag_a    = w_sign_a ? -SrcA : SrcA;
  assign w_mag_b    = w_sign_b ? -SrcB : SrcB;

  assign w_div0 = Operation[2] && (SrcB == '0);
  // Only the signed divide ops (DIV, REM) have bit 0 clear.
  assign w_ovf  = Operation[2] && !Operation[0] &&
                  (SrcA == c_MIN_NEG) && (SrcB == '1);

`ifdef MULDIV_ZERO_SKIP_EN
  assign w_mul_zero = !Operation[2] && ((SrcA == '0) || (SrcB == '0));
`else
  assign w_mul_zero = 1'b0;
`endif

  assign w_special = w_div0 | w_ovf | w_mul_zero;

  // Operation[1] separates REM/REMU from DIV/DIVU among the divide ops.
  always_comb begin
    w_spec_val = '0;
    if (w_div0)     w_spec_val = Operation[1] ? SrcA : '1;
    else if (w_ovf) w_spec_val = Operation[1] ? '0 : c_MIN_NEG;
  end

  assign w_accept = (r_state == c_IDLE) && start && !flush;

  // ---------------- one iteration of the shared datapath ----------------
  logic [DATA_WIDTH-1:0]   w_hi, w_lo;
  logic [DATA_WIDTH:0]     w_mul_sum, w_shift, w_trial;
  logic [c_CW-1:0]         w_bitidx;
  logic                    w_ge;
  logic [2*DATA_WIDTH-1:0] w_mul_next, w_div_next;

  assign w_hi = r_acc[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_lo = r_acc[DATA_WIDTH-1:0];

  // Multiplier bits are taken LSB first from r_b; the carry of the add
  // becomes the new accumulator MSB after the right shift.
  assign w_mul_sum  = {1'b0, w_hi} + (r_b[r_cnt] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_mul_sum, w_lo[DATA_WIDTH-1:1]};

  // Dividend bits are fed MSB first into the remainder; the remainder is
  // widened by one bit so the trial subtract sign is exact.
  assign w_bitidx   = c_CW'(DATA_WIDTH-1) - r_cnt;
  assign w_shift    = {w_hi, r_a[w_bitidx]};
  assign w_trial    = w_shift - {1'b0, r_b};
  assign w_ge       = !w_trial[DATA_WIDTH];
  assign w_div_next = {(w_ge ? w_trial[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0]),
                       w_lo[DATA_WIDTH-2:0], w_ge};

  // ---------------- sign correction and result select ----------------
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0]   w_quot, w_rem, w_final, w_result;

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quot = r_neg ? -w_lo : w_lo;
  assign w_rem  = r_neg_rem ? -w_hi : w_hi;

  always_comb begin
    w_final = '0;
    case (r_op)
      c_MUL:   w_final = w_prod[DATA_WIDTH-1:0];
      3'b001,
      3'b010,
      3'b011:  w_final = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
      3'b100,
      3'b101:  w_final = w_quot;
      default: w_final = w_rem;
    endcase
  end

  // The corrected value is presented directly in the FINISH cycle so done
  // and Result coincide; special cases were already written to r_result.
  assign w_result = ((r_state == c_FINISH) && !r_special && !flush) ? w_final : r_result;
  assign Result   = w_result;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (start && !flush) w_next = w_special ? c_FINISH : c_CALC;
      end
      c_CALC: begin
        if (flush)                                   w_next = c_IDLE;
        else if (r_cnt == c_CW'(DATA_WIDTH-1))       w_next = c_FINISH;
      end
      default: w_next = c_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (r_state != c_IDLE);
    done = (r_state == c_FINISH) && !flush;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_special <= 1'b0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_op      <= Operation;
      r_a       <= w_mag_a;
      r_b       <= w_mag_b;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= w_sign_a ^ w_sign_b;
      r_neg_rem <= w_sign_a;
      r_special <= w_special;
      if (w_special) r_result <= w_spec_val;
    end else if (r_state == c_CALC && !flush) begin
      r_acc <= r_op[2] ? w_div_next : w_mul_next;
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == c_FINISH && !flush) begin
      r_result <= w_result;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit. A reference model built
//            from plain 64-bit arithmetic tracks when each operation must
//            complete and what it must return; a per-cycle compare process
//            checks busy/done/Result against it, and directed vectors check
//            hand-computed results and latencies.
// Options  : honours `define MULDIV_ZERO_SKIP_EN for expected latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    Operation = '0;
  logic [DW-1:0] SrcA = '0;
  logic [DW-1:0] SrcB = '0;
  logic          busy, done;
  logic [DW-1:0] Result;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
    .busy(busy), .done(done), .Result(Result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned up;
    logic [63:0]     v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v  = '0;
    case (op)
      3'd0: begin sp = sa * sb; v = sp; return v[31:0]; end
      3'd1: begin sp = sa * sb; v = sp; return v[63:32]; end
      3'd2: begin sp = sa * longint'({32'h0, b}); v = sp; return v[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; v = up; return v[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sa / sb; v = sp; return v[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        sp = sa % sb; v = sp; return v[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_ZERO_SKIP_EN
    if (!op[2] && (a == 0 || b == 0)) return 1;
`endif
    return DW + 1;
  endfunction

  int          cyc = 0;
  int          m_fin = 0;
  logic        m_active = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_last = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_last   <= '0;
      cyc      <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_active) begin
        if (flush || cyc == m_fin) m_active <= 1'b0;
        if (!flush && cyc == m_fin) m_last <= m_res;
      end else if (start && !flush) begin
        m_active <= 1'b1;
        m_res    <= ref_result(Operation, SrcA, SrcB);
        m_fin    <= cyc + ref_lat(Operation, SrcA, SrcB);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset) begin
      logic exp_done;
      exp_done = m_active && (cyc == m_fin) && !flush;
      chk("busy", {31'b0, busy}, {31'b0, m_active});
      chk("done", {31'b0, done}, {31'b0, exp_done});
      if (exp_done)       chk("Result@done", Result, m_res);
      else if (!m_active) chk("Result@idle", Result, m_last);
    end
  end

  // ---------------- directed vectors ----------------
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int n;
    @(posedge clk); #1;
    Operation = op; SrcA = a; SrcB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    SrcA = $urandom; SrcB = $urandom;  // must not affect the accepted operation
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " latency"}, n, exp_lat);
    chk({name, " result"}, Result, exp_res);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int zlat;
`ifdef MULDIV_ZERO_SKIP_EN
    zlat = 1;
`else
    zlat = DW + 1;
`endif

    // Model pins: hand-computed values.
    chk("model MUL", ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("model MULHU", ref_result(3'd3, 32'd7, 32'hFFFF_FFFD), 32'h0000_0006);
    chk("model DIV", ref_result(3'd4, 32'hFFFF_FFEC, 32'd6), 32'hFFFF_FFFD);
    chk("model REM", ref_result(3'd6, 32'hFFFF_FFEC, 32'd6), 32'hFFFF_FFFE);

    #12;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset Result", Result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_op("MUL 7*-3",     3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("MULH 7*-3",    3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_op("MULHU 7*-3",   3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33);
    run_op("MULHSU 7*-3",  3'd2, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33);
    run_op("MULHSU -3*7",  3'd2, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 33);
    run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("DIV -20/6",    3'd4, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 33);
    run_op("REM -20/6",    3'd6, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 33);
    run_op("DIVU 100/7",   3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("DIVU /0",      3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REMU /0",      3'd7, 32'h1234, 32'd0, 32'h0000_1234, 1);
    run_op("DIV ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("MUL 0*5",      3'd0, 32'd0, 32'd5, 32'd0, zlat);
    run_op("REMU 100/7",   3'd7, 32'd100, 32'd7, 32'd2, 33);

    // Flush at iteration 10 of a MULHU: no done, Result keeps 2.
    @(posedge clk); #1;
    Operation = 3'd3; SrcA = 32'd7; SrcB = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'd0);
    chk("flush done", {31'b0, done}, 32'd0);
    chk("flush Result", Result, 32'd2);
    repeat (40) begin @(posedge clk); #1; end
    chk("flush Result later", Result, 32'd2);

    // Start pulse while busy is ignored; original result at original time.
    Operation = 3'd0; SrcA = 32'd7; SrcB = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    repeat (5) begin @(posedge clk); #1; n++; end
    Operation = 3'd5; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    n++;
    start = 1'b0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    chk("busy-start latency", n, 33);
    chk("busy-start result", Result, 32'hFFFF_FFEB);

    // Asynchronous reset at iteration 20 of a MULHU.
    @(posedge clk); #1;
    Operation = 3'd3; SrcA = 32'd7; SrcB = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset done", {31'b0, done}, 32'd0);
    chk("midreset Result", Result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_op("post-reset DIV", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, in parallel with the ALU.
- Takes the same SrcA/SrcB operands as the ALU and produces a result for the same writeback mux that consumes ALUResult.
- Multi-cycle operation; the hazard unit holds the pipeline while busy is high.
- Radix-2 shift-add multiplier and restoring divider share one accumulator datapath.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- flush  input  1  abort current operation (branch mispredict/pipeline flush).
- Operation  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  DATA_WIDTH  rs1 operand (multiplicand/dividend).
- SrcB  input  DATA_WIDTH  rs2 operand (multiplier/divisor).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; Result valid in that cycle.
- Result  output  DATA_WIDTH  result; holds its value until the next accepted start.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; busy=0, done=0, Result=0; all internal registers cleared.
- FSM states: IDLE, CALC, FINISH.
- IDLE -> CALC on start=1:
  - Latch Operation.
  - Latch operand magnitudes and sign flags. Signed ops: DIV, REM, MULH (both operands), MULHSU (SrcA only).
  - Clear the 2*DATA_WIDTH accumulator and the iteration counter.
- IDLE -> FINISH directly on start=1 when a special case applies (divide ops only):
  - Divide by zero (SrcB=0): DIV/DIVU give all ones; REM/REMU give SrcA.
  - Signed overflow (SrcA=0x80000000, SrcB=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: one iteration per cycle; counter 0..DATA_WIDTH-1. Move to FINISH after iteration DATA_WIDTH-1.
  - Multiply: if multiplier LSB=1, add multiplicand to the upper half; shift the accumulator right 1.
  - Divide: shift the remainder:quotient pair left 1; trial-subtract the divisor; keep the result and set the quotient bit if non-negative.
- FINISH:
  - Apply sign correction. Product negated if the operand signs differ. Quotient negated if the signs differ. Remainder takes the dividend's sign.
  - Select the output: MUL gives the low word; MULH/MULHSU/MULHU give the high word; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Register Result, pulse done=1, then return to IDLE.
- Latency, start edge to done:
  - Normal operation: DATA_WIDTH+1 cycles after the accepting edge (33 for 32-bit); done is high in the 34th cycle counted from start.
  - Special case: 1 cycle.
- busy is 1 in CALC and FINISH and 0 in IDLE. done and busy are both 1 in the FINISH cycle.
- start while busy: ignored; no queueing.
- start in the same cycle done is high: ignored; the requester re-asserts start the next cycle.
- flush in any state: return to IDLE next edge. No done pulse; Result keeps its previous value. flush beats start when both are high in IDLE.
- Reset asserted mid-operation: immediate return to IDLE; outputs cleared.
- Operands are sampled only on the accepting edge; later changes on SrcA/SrcB have no effect.

Optional Feature:
- Macro: MULDIV_ZERO_SKIP_EN.
- Defined: multiply ops with SrcA=0 or SrcB=0 skip CALC and take IDLE -> FINISH with Result=0. Latency is 1 cycle, same as the divide special cases.
- Undefined: all multiply ops run the full DATA_WIDTH iterations. Results are identical either way; only latency differs.

Test Plan:
- MUL SrcA=7, SrcB=-3 (0xFFFFFFFD) -> done 33 cycles after start, Result=0xFFFFFFEB; MULH of the same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- DIV SrcA=-20, SrcB=6 -> Result=0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFE (-2); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU SrcB=0, SrcA=0x1234 -> done 1 cycle after start, Result=0xFFFFFFFF; REM SrcA=0x80000000, SrcB=0xFFFFFFFF -> 0 after 1 cycle.
- Start a MULHU, then:
  - Assert flush at iteration 10 -> busy drops next cycle, no done, Result unchanged.
  - Assert reset at iteration 20 -> busy=0, Result=0 immediately.
- While busy, pulse start with different operands -> ignored; the original operation's result is returned at the original done time.
- With MULDIV_ZERO_SKIP_EN: MUL SrcA=0, SrcB=5 -> done after 1 cycle, Result=0. Without the macro -> done after 33 cycles, Result=0.
